// File: rtl/fp_pkg.sv
// Shared FP register file definitions for the functional units and the writeback path.
package fp_pkg;

    localparam int unsigned FP_REGS   = 32;
    localparam int unsigned FP_ADDR_W = 5;
    localparam int unsigned FP_DATA_W = 16;

    // One writeback payload as produced by a functional unit.
    typedef struct packed {
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, priority starts after the last winner.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant_c,
    output logic [ID_W-1:0] grant_idx_c
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    // Scan requesters starting at ptr+1, wrapping, and pick the first valid one.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = ID_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
                found        = 1'b1;
            end
        end
    end

    // Remember the last winner; reset makes requester 0 the first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(N - 1);
        end else if (|req) begin
            ptr <= grant_idx_c;
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP regfile writeback arbiter with registered write port and per-register busy scoreboard.
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = FP_ADDR_W,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic [ADDR_W-1:0]         q_rs_a,
    input  logic [ADDR_W-1:0]         q_rs_b,
    input  logic [ADDR_W-1:0]         q_rd,
    output logic                      busy_rs_a,
    output logic                      busy_rs_b,
    output logic                      busy_rd,
    input  logic                      flush,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    grant_idx_c;
    logic               grant_any_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign req_ready   = grant_c;
    assign grant_any_c = |grant_c;

    // Steer the granted requester's payload towards the output register.
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: one write per cycle, writes to x0 are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else begin
            rf_we <= grant_any_c && (sel_addr_c != '0);
            if (grant_any_c) begin
                rf_waddr <= sel_addr_c;
                rf_wdata <= sel_data_c;
                grant_id <= grant_idx_c;
            end
        end
    end

    // Next busy state: flush wins, otherwise a new producer overrides a retiring write.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (rf_we) begin
                busy_d[rf_waddr] = 1'b0;
            end
            if (iss_valid && (iss_rd != '0)) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_rs_a = busy_q[q_rs_a];
    assign busy_rs_b = busy_q[q_rs_b];
    assign busy_rd   = busy_q[q_rd];

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter with a cycle-level reference model.
module tb_fp_wb_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   q_rs_a;
    logic [AW-1:0]   q_rs_b;
    logic [AW-1:0]   q_rd;
    logic            busy_rs_a;
    logic            busy_rs_b;
    logic            busy_rd;
    logic            flush;
    logic [1:0]      grant_id;

    int n_vec = 0;
    int n_err = 0;

    fp_wb_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_rs_a(q_rs_a), .q_rs_b(q_rs_b), .q_rd(q_rd),
        .busy_rs_a(busy_rs_a), .busy_rs_b(busy_rs_b), .busy_rd(busy_rd),
        .flush(flush), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_last;        // index of the most recent winner
    bit          m_busy [32];
    bit          m_we;
    int          m_waddr;
    int          m_wdata;
    int          m_gid;

    function automatic int pick_winner();
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_last + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = NR - 1;
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_we = 1'b0; m_waddr = 0; m_wdata = 0; m_gid = 0;
        end else begin
            int w;
            int a;
            w = pick_winner();
            // pending write that completes at this edge retires its register
            if (flush) begin
                foreach (m_busy[r]) m_busy[r] = 1'b0;
            end else begin
                if (m_we) m_busy[m_waddr] = 1'b0;
                if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
            if (w >= 0) begin
                a = int'(req_addr[w*AW +: AW]);
                m_last  = w;
                m_we    = (a != 0);
                m_waddr = a;
                m_wdata = int'(req_data[w*DW +: DW]);
                m_gid   = w;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic [NR-1:0] exp_rdy;
            int w;
            exp_rdy = '0;
            w = pick_winner();
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
                chk("grant_id", 32'(grant_id), 32'(m_gid));
            end
            chk("busy_rs_a", 32'(busy_rs_a), 32'(m_busy[q_rs_a]));
            chk("busy_rs_b", 32'(busy_rs_b), 32'(m_busy[q_rs_b]));
            chk("busy_rd",   32'(busy_rd),   32'(m_busy[q_rd]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        iss_valid = 1'b0; iss_rd = '0; q_rs_a = '0; q_rs_b = '0; q_rd = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_we", 32'(rf_we), 32'd0);
            chk("idle_busy_x0", 32'(busy_rs_a), 32'd0);
            tick();
        end

        // 2: three requesters contending continuously
        set_req(0, 5'd3, 16'h1111);
        set_req(1, 5'd4, 16'h2222);
        set_req(2, 5'd5, 16'h3333);
        req_valid = 3'b111;
        for (int c = 0; c < 9; c++) begin
            logic [NR-1:0] oh;
            oh = '0;
            oh[c % 3] = 1'b1;
            @(negedge clk);
            chk("rr_order", 32'(req_ready), 32'(oh));
            if (c > 0) begin
                chk("rr_we", 32'(rf_we), 32'd1);
                chk("rr_waddr", 32'(rf_waddr), 32'(3 + ((c - 1) % 3)));
            end
            tick();
            if (c >= 6) req_valid[c % 3] = 1'b0;
        end
        @(negedge clk);
        chk("rr_last_waddr", 32'(rf_waddr), 32'd5);
        chk("rr_last_wdata", 32'(rf_wdata), 32'h3333);
        tick();

        // 3: issue to f7, then requester 1 retires it
        iss_valid = 1'b1; iss_rd = 5'd7; q_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        set_req(1, 5'd7, 16'h3C00);
        req_valid = 3'b010;
        @(negedge clk);
        chk("t3_busy_set", 32'(busy_rd), 32'd1);
        chk("t3_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t3_we", 32'(rf_we), 32'd1);
        chk("t3_waddr", 32'(rf_waddr), 32'd7);
        chk("t3_wdata", 32'(rf_wdata), 32'h3C00);
        chk("t3_busy_during_we", 32'(busy_rd), 32'd1);
        tick();
        @(negedge clk);
        chk("t3_busy_cleared", 32'(busy_rd), 32'd0);

        // 4a: re-issue to f9 on the cycle its old write retires
        iss_valid = 1'b1; iss_rd = 5'd9; q_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        set_req(0, 5'd9, 16'h4400);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        chk("t4_we9", 32'(rf_we), 32'd1);
        chk("t4_waddr9", 32'(rf_waddr), 32'd9);
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", 32'(busy_rd), 32'd1);

        // 4b: flush beats a same-cycle issue
        iss_valid = 1'b1; iss_rd = 5'd10; flush = 1'b1;
        tick();
        iss_valid = 1'b0; flush = 1'b0; q_rd = 5'd10; q_rs_a = 5'd9;
        @(negedge clk);
        chk("t4_flush_wins", 32'(busy_rd), 32'd0);
        chk("t4_flush_clr9", 32'(busy_rs_a), 32'd0);

        // 5: write to x0 is consumed but not performed
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0; q_rs_a = 5'd12; q_rs_b = 5'd0;
        set_req(2, 5'd0, 16'hFFFF);
        req_valid = 3'b100;
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t5_no_we", 32'(rf_we), 32'd0);
        chk("t5_busy12", 32'(busy_rs_a), 32'd1);
        chk("t5_busy_x0", 32'(busy_rs_b), 32'd0);
        tick();

        // 6: async reset in the middle of a stream
        set_req(0, 5'd3, 16'h1111);
        set_req(1, 5'd4, 16'h2222);
        set_req(2, 5'd5, 16'h3333);
        req_valid = 3'b111;
        iss_valid = 1'b1; iss_rd = 5'd13; q_rd = 5'd13;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("t6_pre_we", 32'(rf_we), 32'd1);
        chk("t6_pre_busy", 32'(busy_rd), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(rf_we), 32'd0);
        chk("t6_rst_busy", 32'(busy_rd), 32'd0);
        chk("t6_rst_busy12", 32'(busy_rs_a), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_first_grant", 32'(req_ready), 32'b001);
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid[c] = 1'b0;
        end
        @(negedge clk);
        chk("t6_last_waddr", 32'(rf_waddr), 32'd5);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
